// File: rtl/debug_run_controller.sv
// debug_run_controller
// Host-facing run/step/halt controller for the multicycle CPU. It produces
// run_en, which gates the control unit's write enables, and sequences debug
// memory, register and PC writes while the CPU is halted. It also counts the
// cycles in which the CPU was allowed to execute.
// Optional feature: define BREAKPOINT_EN to add a single PC breakpoint.
// With it, host_cmd 0 becomes SETBP.
module debug_run_controller #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              host_req,
    input  logic [2:0]        host_cmd,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_data,
    output logic              host_ack,
    output logic              host_err,
    input  logic              cpu_fetch,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              run_en,
    output logic              dbg_mem_we,
    output logic              dbg_reg_we,
    output logic              dbg_pc_load,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [15:0]       dbg_data,
    output logic [1:0]        mode,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              bp_hit
);

    typedef enum logic [2:0] {
        S_HALT, S_RUN, S_DRAIN, S_STEP_LEAVE, S_STEP_FINISH, S_WRITE, S_ACK
    } state_t;

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_HALT   = 3'd1;
    localparam logic [2:0] CMD_RUN    = 3'd2;
    localparam logic [2:0] CMD_STEP   = 3'd3;
    localparam logic [2:0] CMD_MEMWR  = 3'd4;
    localparam logic [2:0] CMD_REGWR  = 3'd5;
    localparam logic [2:0] CMD_SETPC  = 3'd6;
    localparam logic [2:0] CMD_CLRCNT = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    logic [2:0] cmd_q;     // command latched at acceptance, selects the write strobe
    logic       ret_run;   // return state after S_ACK: 1 = RUN, 0 = HALT
    logic       err_q;     // rejection flag reported alongside host_ack
    logic       accept;
    logic       bp_trig;

`ifdef BREAKPOINT_EN
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_valid;
    logic              bp_armed;  // set once the CPU has left fetch since entering S_RUN

    assign bp_trig = (state == S_RUN) && cpu_fetch && bp_valid && bp_armed &&
                     (cpu_pc == bp_addr);
    assign bp_hit  = bp_trig;

    // Breakpoint address capture and re-arm tracking
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bp_addr  <= '0;
            bp_valid <= 1'b0;
            bp_armed <= 1'b0;
        end else begin
            if (accept && host_cmd == CMD_NOP) begin
                bp_addr  <= host_addr;
                bp_valid <= 1'b1;
            end
            if (state != S_RUN)
                bp_armed <= 1'b0;
            else if (!cpu_fetch)
                bp_armed <= 1'b1;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^cpu_pc;
    assign bp_trig   = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    // A breakpoint halt pre-empts a host command arriving in the same cycle;
    // the host request is then taken up from S_HALT.
    assign accept = host_req && (state == S_HALT || state == S_RUN) && !bp_trig;

    assign host_ack    = (state == S_ACK);
    assign host_err    = (state == S_ACK) && err_q;
    assign dbg_mem_we  = (state == S_WRITE) && (cmd_q == CMD_MEMWR);
    assign dbg_reg_we  = (state == S_WRITE) && (cmd_q == CMD_REGWR);
    assign dbg_pc_load = (state == S_WRITE) && (cmd_q == CMD_SETPC);

    // Execution enable; drains and steps release the CPU in the very cycle it reaches fetch
    always_comb begin
        run_en = 1'b0;
        case (state)
            S_RUN:                  run_en = !bp_trig;
            S_STEP_LEAVE:           run_en = 1'b1;
            S_DRAIN, S_STEP_FINISH: run_en = !cpu_fetch;
            S_ACK:                  run_en = ret_run;
            default:                run_en = 1'b0;
        endcase
    end

    // Host-visible mode; while acknowledging, report where we are returning to
    always_comb begin
        mode = 2'd0;
        case (state)
            S_RUN:                       mode = 2'd1;
            S_STEP_LEAVE, S_STEP_FINISH: mode = 2'd2;
            S_DRAIN:                     mode = 2'd3;
            S_ACK:                       mode = ret_run ? 2'd1 : 2'd0;
            default:                     mode = 2'd0;
        endcase
    end

    // Command sequencing FSM with host latches
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_HALT;
            cmd_q    <= '0;
            ret_run  <= 1'b0;
            err_q    <= 1'b0;
            dbg_addr <= '0;
            dbg_data <= '0;
        end else begin
            if (accept) begin
                cmd_q    <= host_cmd;
                dbg_addr <= host_addr;
                dbg_data <= host_data;
                err_q    <= 1'b0;
            end
            case (state)
                S_HALT: begin
                    if (accept) begin
                        ret_run <= 1'b0;
                        case (host_cmd)
                            CMD_MEMWR, CMD_REGWR, CMD_SETPC: state <= S_WRITE;
                            CMD_STEP: state <= S_STEP_LEAVE;
                            CMD_RUN: begin
                                ret_run <= 1'b1;
                                state   <= S_ACK;
                            end
                            default: state <= S_ACK;
                        endcase
                    end
                end
                S_RUN: begin
                    if (bp_trig) begin
                        state <= S_HALT;
                    end else if (accept) begin
                        ret_run <= 1'b1;
                        case (host_cmd)
                            CMD_HALT:            state <= S_DRAIN;
                            CMD_NOP, CMD_CLRCNT: state <= S_ACK;
                            default: begin
                                err_q <= 1'b1;
                                state <= S_ACK;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    ret_run <= 1'b0;
                    state   <= S_ACK;
                end
                S_STEP_LEAVE: begin
                    if (!cpu_fetch)
                        state <= S_STEP_FINISH;
                end
                S_STEP_FINISH, S_DRAIN: begin
                    if (cpu_fetch) begin
                        ret_run <= 1'b0;
                        state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!host_req)
                        state <= ret_run ? S_RUN : S_HALT;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Executed-cycle counter; a clear wins over a coincident increment
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            cycle_count <= '0;
        else if (accept && host_cmd == CMD_CLRCNT)
            cycle_count <= '0;
        else if (run_en)
            cycle_count <= cycle_count + CNT_ONE;
    end

endmodule

// File: tb/tb_debug_run_controller.sv
// Testbench for debug_run_controller: directed scenarios followed by random
// host commands, checked against a transaction-level model of the host
// protocol and of which cycles the CPU is allowed to execute.
module tb_debug_run_controller;

    localparam int CNT_W  = 16;
    localparam int ADDR_W = 16;

    localparam logic [2:0] C_NOP = 3'd0, C_HALT = 3'd1, C_RUN = 3'd2, C_STEP = 3'd3;
    localparam logic [2:0] C_MEMWR = 3'd4, C_REGWR = 3'd5, C_SETPC = 3'd6, C_CLRCNT = 3'd7;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              host_req = 1'b0;
    logic [2:0]        host_cmd = 3'd0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [15:0]       host_data = '0;
    logic              host_ack, host_err;
    logic              cpu_fetch = 1'b0;
    logic [ADDR_W-1:0] cpu_pc = '0;
    logic              run_en, dbg_mem_we, dbg_reg_we, dbg_pc_load;
    logic [ADDR_W-1:0] dbg_addr;
    logic [15:0]       dbg_data;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  cycle_count;
    logic              bp_hit;

    debug_run_controller #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .host_req(host_req), .host_cmd(host_cmd), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack), .host_err(host_err),
        .cpu_fetch(cpu_fetch), .cpu_pc(cpu_pc),
        .run_en(run_en), .dbg_mem_we(dbg_mem_we), .dbg_reg_we(dbg_reg_we), .dbg_pc_load(dbg_pc_load),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .mode(mode),
        .cycle_count(cycle_count), .bp_hit(bp_hit)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic             running = 1'b0;  // CPU executes freely between commands
    logic [CNT_W-1:0] m_cnt = '0;      // expected executed-cycle count
    logic             exp_bp = 1'b0;   // expected breakpoint pulse this cycle
    bit               fq[$];           // scripted cpu_fetch values, random when empty

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick_fetch();
        if (fq.size() > 0) return fq.pop_front();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: inputs are already driven; check outputs at the falling edge.
    task automatic cyc(input logic exp_run, input logic [1:0] exp_mode, input logic [2:0] exp_we,
                       input logic exp_ack, input logic exp_err);
        @(negedge CLK);
        chk("run_en", 32'(run_en), 32'(exp_run));
        chk("mode", 32'(mode), 32'(exp_mode));
        chk("strobes", 32'({dbg_mem_we, dbg_reg_we, dbg_pc_load}), 32'(exp_we));
        chk("host_ack", 32'(host_ack), 32'(exp_ack));
        chk("host_err", 32'(host_err), 32'(exp_err));
        chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
        chk("bp_hit", 32'(bp_hit), 32'(exp_bp));
        if (exp_run) m_cnt = m_cnt + 16'd1;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_fetch = pick_fetch();
            cyc(running, running ? 2'd1 : 2'd0, 3'b000, 1'b0, 1'b0);
        end
    endtask

    // Issue one host command and follow it through to the end of its acknowledge.
    task automatic do_cmd(input logic [2:0] cmd, input logic [15:0] addr, input logic [15:0] data,
                          input int hold, input bit early);
        logic       was_run, nxt_run, err, f;
        logic [2:0] we;
        int         k;
        was_run   = running;
        nxt_run   = running;
        err       = 1'b0;
        host_req  = 1'b1;
        host_cmd  = cmd;
        host_addr = addr;
        host_data = data;
        cpu_fetch = pick_fetch();
        cyc(was_run, was_run ? 2'd1 : 2'd0, 3'b000, 1'b0, 1'b0);
        if (cmd == C_CLRCNT) m_cnt = '0;
        if (early) host_req = 1'b0;
        if (!was_run) begin
            if (cmd == C_MEMWR || cmd == C_REGWR || cmd == C_SETPC) begin
                we = (cmd == C_MEMWR) ? 3'b100 : (cmd == C_REGWR) ? 3'b010 : 3'b001;
                cpu_fetch = pick_fetch();
                cyc(1'b0, 2'd0, we, 1'b0, 1'b0);
                chk("dbg_addr", 32'(dbg_addr), 32'(addr));
                chk("dbg_data", 32'(dbg_data), 32'(data));
            end else if (cmd == C_RUN) begin
                nxt_run = 1'b1;
            end else if (cmd == C_STEP) begin
                k = 0;
                do begin
                    cpu_fetch = (k > 20) ? 1'b0 : pick_fetch();
                    f = cpu_fetch;
                    cyc(1'b1, 2'd2, 3'b000, 1'b0, 1'b0);
                    k++;
                end while (f);
                k = 0;
                do begin
                    cpu_fetch = (k > 20) ? 1'b1 : pick_fetch();
                    f = cpu_fetch;
                    cyc(!f, 2'd2, 3'b000, 1'b0, 1'b0);
                    k++;
                end while (!f);
            end
        end else begin
            if (cmd == C_HALT) begin
                nxt_run = 1'b0;
                k = 0;
                do begin
                    cpu_fetch = (k > 20) ? 1'b1 : pick_fetch();
                    f = cpu_fetch;
                    cyc(!f, 2'd3, 3'b000, 1'b0, 1'b0);
                    k++;
                end while (!f);
            end else if (cmd != C_NOP && cmd != C_CLRCNT) begin
                err = 1'b1;
            end
        end
        running = nxt_run;
        k = 0;
        while (1) begin
            if (k >= hold) host_req = 1'b0;
            cpu_fetch = pick_fetch();
            cyc(nxt_run, nxt_run ? 2'd1 : 2'd0, 3'b000, 1'b1, err);
            if (!host_req) break;
            k++;
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_run_en", 32'(run_en), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_err", 32'(host_err), 32'd0);
        chk("rst_count", 32'(cycle_count), 32'd0);
        chk("rst_dbg_addr", 32'(dbg_addr), 32'd0);
        chk("rst_dbg_data", 32'(dbg_data), 32'd0);
        chk("rst_strobes", 32'({dbg_mem_we, dbg_reg_we, dbg_pc_load}), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        idle(2);

        // Debug memory write while halted
        do_cmd(C_MEMWR, 16'h0040, 16'hBEEF, 2, 1'b0);
        idle(1);
        do_cmd(C_REGWR, 16'h0003, 16'h1234, 0, 1'b0);
        do_cmd(C_SETPC, 16'h0200, 16'h0000, 1, 1'b1);

        // Single step with fetch pattern 1,0,0,0,1
        do_cmd(C_CLRCNT, 16'h0000, 16'h0000, 0, 1'b0);
        fq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_cmd(C_STEP, 16'h0000, 16'h0000, 1, 1'b0);
        chk("step_count", 32'(cycle_count), 32'd4);
        chk("step_mode", 32'(mode), 32'd0);

        // Run, then a rejected write while running
        do_cmd(C_RUN, 16'h0000, 16'h0000, 1, 1'b0);
        idle(3);
        do_cmd(C_MEMWR, 16'h0080, 16'hCAFE, 2, 1'b0);
        idle(2);
        do_cmd(C_CLRCNT, 16'h0000, 16'h0000, 1, 1'b1);
        idle(2);

        // Halt while the CPU stays out of fetch for three cycles
        fq = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_cmd(C_HALT, 16'h0000, 16'h0000, 1, 1'b0);

        // Halt when the CPU is already at fetch
        do_cmd(C_RUN, 16'h0000, 16'h0000, 0, 1'b0);
        fq = '{1'b1, 1'b1};
        do_cmd(C_HALT, 16'h0000, 16'h0000, 0, 1'b0);

        // Random host traffic
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  c;
            logic [15:0] a;
            c = 3'($urandom_range(0, 7));
            a = (c == C_NOP) ? 16'h0010 : 16'($urandom);
            do_cmd(c, a, 16'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            idle(int'($urandom_range(0, 3)));
        end

        // Reset while running
        if (!running) do_cmd(C_RUN, 16'h0000, 16'h0000, 0, 1'b0);
        idle(3);
        RESET = 1'b0;
        #2;
        chk("midrst_run_en", 32'(run_en), 32'd0);
        chk("midrst_mode", 32'(mode), 32'd0);
        chk("midrst_count", 32'(cycle_count), 32'd0);
        chk("midrst_ack", 32'(host_ack), 32'd0);
        @(posedge CLK);
        #1;
        RESET   = 1'b1;
        running = 1'b0;
        m_cnt   = '0;
        idle(2);

`ifdef BREAKPOINT_EN
        // Breakpoint at the resume PC: first fetch ignored, second one halts
        do_cmd(C_NOP, 16'h0010, 16'h0000, 0, 1'b0);
        cpu_pc = 16'h0010;
        fq = '{1'b0, 1'b1};
        do_cmd(C_RUN, 16'h0000, 16'h0000, 0, 1'b0);
        cpu_fetch = 1'b1;
        cyc(1'b1, 2'd1, 3'b000, 1'b0, 1'b0);
        cpu_fetch = 1'b0;
        cyc(1'b1, 2'd1, 3'b000, 1'b0, 1'b0);
        cpu_fetch = 1'b1;
        exp_bp = 1'b1;
        cyc(1'b0, 2'd1, 3'b000, 1'b0, 1'b0);
        exp_bp  = 1'b0;
        running = 1'b0;
        cpu_fetch = 1'b0;
        cyc(1'b0, 2'd0, 3'b000, 1'b0, 1'b0);
        cpu_pc = '0;
        idle(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debug_run_controller.md
Name: debug_run_controller

Overview:
- Host-facing run/step/halt controller for the multicycle CPU.
- Sits between a host debug port (switch/UART bridge) and the datapath plus control unit.
- Produces `run_en`, which gates the control unit's write enables (FU, RW, PCW, SPW, MW, IW).
- Sequences debug memory, register and PC writes over the datapath's debug write ports while the CPU is halted, and counts executed cycles.

Parameters:
- CNT_W, 16, width of cycle counter.
- ADDR_W, 16, width of host_addr / dbg_addr / cpu_pc.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- host_req  in  1  command request, four-phase handshake.
- host_cmd  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 MEMWR, 5 REGWR, 6 SETPC, 7 CLRCNT.
- host_addr  in  ADDR_W  memory address / register number (low 4 bits) / new PC.
- host_data  in  16  write data.
- host_ack  out  1  command done; held until host_req low.
- host_err  out  1  valid with host_ack; command rejected.
- cpu_fetch  in  1  control unit is in its fetch state.
- cpu_pc  in  ADDR_W  current PC.
- run_en  out  1  enables control-unit writes.
- dbg_mem_we  out  1  one-cycle debug memory write.
- dbg_reg_we  out  1  one-cycle debug register write.
- dbg_pc_load  out  1  one-cycle PC load.
- dbg_addr  out  ADDR_W  latched host_addr.
- dbg_data  out  16  latched host_data.
- mode  out  2  0 halted, 1 running, 2 stepping, 3 draining.
- cycle_count  out  CNT_W  cycles with run_en=1.
- bp_hit  out  1  breakpoint halt pulse.

Behaviour:
Reset (RESET=0, asynchronous):
- State S_HALT.
- All outputs 0, including cycle_count and the return-state register.

States: S_HALT, S_RUN, S_DRAIN, S_STEP_LEAVE, S_STEP_FINISH, S_WRITE, S_ACK.

Command acceptance:
- A command is accepted on a rising edge with host_req=1 in S_HALT or S_RUN.
- host_cmd/addr/data are latched into dbg_addr/dbg_data at acceptance.

From S_HALT:
- MEMWR, REGWR, SETPC: go to S_WRITE. That state asserts exactly one of dbg_mem_we / dbg_reg_we / dbg_pc_load for one cycle, then goes to S_ACK with return state HALT.
- RUN: return state RUN, then S_ACK.
- STEP: go to S_STEP_LEAVE (run_en=1). Move to S_STEP_FINISH once cpu_fetch=0. In S_STEP_FINISH, on cpu_fetch=1, run_en drops combinationally in that same cycle and the FSM goes to S_ACK with return state HALT.
- HALT, NOP: go to S_ACK.

From S_RUN (run_en=1):
- HALT: go to S_DRAIN. run_en stays 1 until cpu_fetch=1, then 0 combinationally in that cycle. Then S_ACK with return state HALT.
- NOP, CLRCNT: acknowledged, return state RUN. run_en stays 1 during S_ACK.
- MEMWR, REGWR, SETPC, STEP, RUN: acknowledged with host_err=1. No side effect; keep running.

S_DRAIN entered with cpu_fetch already 1: halts in the first S_DRAIN cycle.

S_ACK:
- host_ack=1, with host_err as decided at acceptance.
- Stay until host_req=0, then go to the return state.
- run_en in S_ACK equals 1 only if the return state is RUN.

cycle_count:
- Increments each cycle run_en=1; wraps from all-ones to 0.
- CLRCNT clears it at acceptance. If clear and increment coincide, the result is 0.

mode output:
- 0 in S_HALT and S_WRITE.
- 1 in S_RUN.
- 2 in S_STEP_*.
- 3 in S_DRAIN.
- In S_ACK, reflects the return state.

host_req falling early, before ack: ignored; the command completes and ack then drops on the next cycle.

Optional Feature:
BREAKPOINT_EN
- Defined:
  - host_cmd 0 becomes SETBP: bp_addr=host_addr, bp_valid=1; acknowledged in HALT or RUN.
  - Breakpoint halt: in S_RUN, with cpu_fetch=1 and cpu_pc==bp_addr and bp_valid, run_en drops combinationally, bp_hit pulses one cycle, and the FSM goes to S_HALT (no host ack).
  - Comparison is armed only after cpu_fetch has been 0 at least once since entering S_RUN, so resuming at the breakpoint PC does not retrigger.
  - Reset clears bp_valid.
- Undefined: cmd 0 is NOP, bp_hit tied 0, no bp registers.

Test Plan:
- Reset mid-RUN (RESET low 1 cycle while run_en=1) -> next cycle mode=0, run_en=0, cycle_count=0, host_ack=0.
- HALT state, MEMWR addr=0x0040 data=0xBEEF -> exactly one cycle dbg_mem_we=1 with dbg_addr=0x0040, dbg_data=0xBEEF; then host_ack=1, host_err=0 until host_req drops.
- STEP with cpu_fetch sequence 1,0,0,0,1 -> run_en=1 for exactly 4 cycles; ack; mode=0; cycle_count=4.
- RUN, then MEMWR while running -> host_ack=1, host_err=1, dbg_mem_we never asserted, run_en stays 1.
- RUN, then HALT issued while cpu_fetch=0 for 3 more cycles -> mode=3 for 3 cycles; run_en drops the cycle cpu_fetch=1; ack with host_err=0.
- BREAKPOINT_EN: SETBP 0x0010, RUN from PC 0x0010, later fetch at 0x0010 -> no trigger on the first fetch; bp_hit one cycle on the second; mode=0.
